// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int IMEM_ADDR_WIDTH    = DEFAULT_ADDR_WIDTH - 2;
  localparam int IMEM_SIZE          = 1 << IMEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LD = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/imem_arb_starve.sv
// Saturating count of consecutive cycles a pending loader request lost to fetch,
// and the resulting loader-wins decision.
module imem_arb_starve
  import imem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic if_req_i,
  input  logic ld_req_i,
  input  logic ld_gnt_i,
  output logic ld_wins_o
);

  logic [3:0] cnt_q, cnt_d;

  assign ld_wins_o = run_i && if_req_i && ld_req_i && (cnt_q >= 4'(STARVE_LIMIT));

  // Any cycle in which the loader is idle, granted, or the arbiter is not in RUN
  // breaks the losing streak.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || !ld_req_i || ld_gnt_i) begin
      cnt_d = '0;
    end else if (if_req_i) begin
      cnt_d = sat_inc4(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_arb.sv
// Instruction-memory port arbiter: loader-exclusive BOOT, fetch-priority RUN with a
// starvation bound for the loader, and a one-cycle DRAIN before re-entering BOOT.
module imem_arb
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_stall,
  output logic                  if_valid,
  output logic [31:0]           if_data,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [31:0]           ld_rdata,
  input  logic                  ld_done,
  input  logic                  ld_boot,
  output logic                  cpu_hold,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  arb_state_e state_q, state_d;
  logic       rd_pend_q, rd_pend_d;
  logic       owner_q, owner_d;
  logic       if_grant, ld_grant;
  logic       ld_wins;

  imem_arb_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .run_i    (state_q == ST_RUN),
    .if_req_i (if_req),
    .ld_req_i (ld_req),
    .ld_gnt_i (ld_grant),
    .ld_wins_o(ld_wins)
  );

  always_comb begin
    state_d  = state_q;
    if_grant = 1'b0;
    ld_grant = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ld_grant = ld_req;
        if (ld_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if_grant = if_req && !ld_wins;
        ld_grant = ld_req && !if_grant;
        if (ld_boot) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_BOOT;
      default:  state_d = ST_BOOT;
    endcase
    // Keep the memory port quiet for the whole reset cycle.
    if (rst) begin
      if_grant = 1'b0;
      ld_grant = 1'b0;
    end
  end

  always_comb begin
    rd_pend_d = if_grant || (ld_grant && !ld_we);
    owner_d   = owner_q;
    if (rd_pend_d) owner_d = ld_grant ? OWNER_LD : OWNER_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BOOT;
      rd_pend_q <= 1'b0;
      owner_q   <= OWNER_IF;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      owner_q   <= owner_d;
    end
  end

  assign ld_gnt    = ld_grant;
  assign if_stall  = if_req && !if_grant;
  assign cpu_hold  = (state_q != ST_RUN);

  assign mem_en    = if_grant || ld_grant;
  assign mem_we    = ld_grant && ld_we;
  assign mem_addr  = ld_grant ? ld_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
  assign mem_wdata = ld_wdata;

  // Data returning while reset is asserted belongs to a cancelled read.
  assign if_valid  = rd_pend_q && (owner_q == OWNER_IF) && !rst;
  assign ld_rvalid = rd_pend_q && (owner_q == OWNER_LD) && !rst;
  assign if_data   = mem_rdata;
  assign ld_rdata  = mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH], if_addr[1:0],
                              ld_addr[31:ADDR_WIDTH], ld_addr[1:0]};

endmodule

// File: tb/tb_imem_arb.sv
// Randomised scoreboard bench for imem_arb with a behavioural arbitration model.
module tb_imem_arb;

  localparam int AW      = 10;
  localparam int SL      = 4;
  localparam int WORDS   = 1 << (AW - 2);
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_stall, if_valid;
  logic [31:0]   if_addr, if_data;
  logic          ld_req, ld_we, ld_gnt, ld_rvalid, ld_done, ld_boot;
  logic [31:0]   ld_addr, ld_wdata, ld_rdata;
  logic          cpu_hold, mem_en, mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  imem_arb #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_valid(if_valid), .if_data(if_data),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_done(ld_done), .ld_boot(ld_boot),
    .cpu_hold(cpu_hold), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = loader
    logic [31:0] data;
    int          due;
  } rd_t;
  rd_t exp_q[$];

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  // Synchronous single-port memory with registered read data.
  logic [31:0] tb_mem [WORDS];
  bit          tb_wr  [WORDS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        tb_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : pat(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int m_state  = M_BOOT;
  int m_starve = 0;
  bit m_gif, m_gld;
  bit d_ld_gnt, d_if_grant;
  int d_mem_addr;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(WORDS - 1));
  endfunction

  task automatic model_check();
    bit e_if, e_ld;
    int nxt, w;
    e_if = 1'b0;
    e_ld = 1'b0;
    nxt  = m_state;
    d_ld_gnt   = ld_gnt;
    d_if_grant = if_req && !if_stall;
    d_mem_addr = int'(mem_addr);
    if (rst) begin
      chk("rst_mem_en", 32'(mem_en), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      m_state = M_BOOT; m_starve = 0; m_gif = 1'b0; m_gld = 1'b0;
      return;
    end
    if (m_state == M_BOOT) begin
      e_ld = ld_req;
      if (ld_done) nxt = M_RUN;
    end else if (m_state == M_RUN) begin
      if (if_req && ld_req) begin
        if (m_starve >= SL) e_ld = 1'b1;
        else e_if = 1'b1;
      end else begin
        e_if = if_req;
        e_ld = ld_req;
      end
      if (ld_boot) nxt = M_DRAIN;
    end else begin
      nxt = M_BOOT;
    end
    chk("cpu_hold", 32'(cpu_hold), 32'(m_state != M_RUN));
    chk("ld_gnt",   32'(ld_gnt),   32'(e_ld));
    chk("if_stall", 32'(if_stall), 32'(if_req && !e_if));
    chk("mem_en",   32'(mem_en),   32'(e_if || e_ld));
    chk("mem_we",   32'(mem_we),   32'(e_ld && ld_we));
    if (e_if || e_ld) begin
      w = e_ld ? word_of(ld_addr) : word_of(if_addr);
      chk("mem_addr", 32'(mem_addr), 32'(w));
      if (e_ld && ld_we) begin
        chk("mem_wdata", mem_wdata, ld_wdata);
        ref_mem[w] = ld_wdata;
      end else begin
        exp_q.push_back('{port: e_ld, data: ref_mem[w], due: cyc + 1});
      end
    end
    if (m_state == M_RUN && if_req && ld_req && e_if) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
    else m_starve = 0;
    m_state = nxt;
    m_gif = e_if;
    m_gld = e_ld;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares read responses against the scoreboard queue.
  initial begin
    rd_t e;
    bit  ei, el;
    forever begin
      @(negedge clk);
      ei = 1'b0;
      el = 1'b0;
      e.data = '0;
      if (rst) begin
        chk("rst_if_valid",  32'(if_valid),  32'(0));
        chk("rst_ld_rvalid", 32'(ld_rvalid), 32'(0));
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          void'(exp_q.pop_front());
          n_chk++;
          n_err++;
          $display("FAIL stale_read @cyc %0d: got no response expected one", cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          if (e.port) el = 1'b1;
          else ei = 1'b1;
        end
        chk("if_valid",  32'(if_valid),  32'(ei));
        chk("ld_rvalid", 32'(ld_rvalid), 32'(el));
        if (ei) chk("if_data", if_data, e.data);
        if (el) chk("ld_rdata", ld_rdata, e.data);
        if (ei || el) $display("rd cyc=%0d port=%s data=%h", cyc, el ? "ld" : "if", e.data);
      end
    end
  end

  initial begin
    int n, fw;
    bit got, if_pend, ld_pend;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = pat(i);
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0; ld_done = 1'b0; ld_boot = 1'b0;
    step(); step();
    rst = 1'b0;

    // Boot fill with fetch requesting throughout
    if_req = 1'b1; if_addr = 32'h4;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0; ld_wdata = 32'h3c18_0007; step();
    ld_addr = 32'h4; ld_wdata = 32'h3c19_0008; step();
    ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b1; step();
    ld_done = 1'b0; step(); step();

    // Starvation bound, twice to confirm the counter clears after a loader win
    for (int r = 0; r < 2; r++) begin
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0;
      n = 0; fw = 0; got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
        step();
        n++;
        if (d_if_grant) fw++;
        if (d_ld_gnt) got = 1'b1;
      end
      ld_req = 1'b0;
      chk("starve_gnt_cycle", 32'(n), 32'(SL + 1));
      chk("starve_fetch_wins", 32'(fw), 32'(SL));
      step();
    end

    // Owner steering: alternating fetch and loader reads
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; ld_req = 1'b0; if_addr = 32'(i * 4); step();
      if_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h4; step();
    end
    ld_req = 1'b0; step();

    // Re-boot while a fetch is granted, then DRAIN and BOOT
    if_req = 1'b1; if_addr = 32'h0; ld_boot = 1'b1; step();
    ld_boot = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h4; step();
    step();
    ld_req = 1'b0; ld_done = 1'b1; step();
    ld_done = 1'b0;

    // Reset in the cycle after a fetch grant
    if_req = 1'b1; if_addr = 32'h4; step();
    rst = 1'b1; step();
    rst = 1'b0; if_req = 1'b0; step();

    // Address decode of a loader write with ignored bits set
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'hFFFF_FC07; ld_wdata = 32'h1234_5678; step();
    chk("decode_addr", 32'(d_mem_addr), 32'h1);
    ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b1; step();
    ld_done = 1'b0;

    // Randomised traffic with occasional boot, done and reset pulses
    if_pend = 1'b0; ld_pend = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (m_gif) if_pend = 1'b0;
      if (m_gld) ld_pend = 1'b0;
      if (!if_pend && $urandom_range(0, 3) != 0) begin
        if_pend = 1'b1;
        if_addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      end
      if (!ld_pend && $urandom_range(0, 2) == 0) begin
        ld_pend  = 1'b1;
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        ld_wdata = $urandom;
      end
      if_req  = if_pend;
      ld_req  = ld_pend;
      ld_done = (m_state == M_BOOT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0);
      ld_boot = ($urandom_range(0, 40) == 0);
      rst     = ($urandom_range(0, 150) == 0);
      step();
    end

    rst = 1'b0; if_req = 1'b0; ld_req = 1'b0; ld_done = 1'b0; ld_boot = 1'b0;
    step(); step();
    chk("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
